// File: rtl/key_expansion.sv
// AES-256 key schedule: expands a 256-bit key into 60 words, one word per clock,
// and serves any of the 15 round keys combinationally by index.
module key_expansion (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         En,
  input  logic [255:0] data_in,
  input  logic [3:0]   Addr_Key,
  output logic         ready,
  output logic [127:0] Out_Key
);

  // state  | meaning
  // IDLE   | waiting for En, storage holds reset zeros
  // EXPAND | writing w[i], i = 8..59, one word per clock
  // DONE   | schedule complete and frozen until reset
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] w [60];
  logic [5:0]  i;
  logic [5:0]  idx_prev, idx_back, base;
  logic [31:0] w_prev, temp, w_new;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = 8'h00;
    case (x)
      8'h00: sbox = 8'h63; 8'h01: sbox = 8'h7c; 8'h02: sbox = 8'h77; 8'h03: sbox = 8'h7b; 8'h04: sbox = 8'hf2; 8'h05: sbox = 8'h6b; 8'h06: sbox = 8'h6f; 8'h07: sbox = 8'hc5;
      8'h08: sbox = 8'h30; 8'h09: sbox = 8'h01; 8'h0a: sbox = 8'h67; 8'h0b: sbox = 8'h2b; 8'h0c: sbox = 8'hfe; 8'h0d: sbox = 8'hd7; 8'h0e: sbox = 8'hab; 8'h0f: sbox = 8'h76;
      8'h10: sbox = 8'hca; 8'h11: sbox = 8'h82; 8'h12: sbox = 8'hc9; 8'h13: sbox = 8'h7d; 8'h14: sbox = 8'hfa; 8'h15: sbox = 8'h59; 8'h16: sbox = 8'h47; 8'h17: sbox = 8'hf0;
      8'h18: sbox = 8'had; 8'h19: sbox = 8'hd4; 8'h1a: sbox = 8'ha2; 8'h1b: sbox = 8'haf; 8'h1c: sbox = 8'h9c; 8'h1d: sbox = 8'ha4; 8'h1e: sbox = 8'h72; 8'h1f: sbox = 8'hc0;
      8'h20: sbox = 8'hb7; 8'h21: sbox = 8'hfd; 8'h22: sbox = 8'h93; 8'h23: sbox = 8'h26; 8'h24: sbox = 8'h36; 8'h25: sbox = 8'h3f; 8'h26: sbox = 8'hf7; 8'h27: sbox = 8'hcc;
      8'h28: sbox = 8'h34; 8'h29: sbox = 8'ha5; 8'h2a: sbox = 8'he5; 8'h2b: sbox = 8'hf1; 8'h2c: sbox = 8'h71; 8'h2d: sbox = 8'hd8; 8'h2e: sbox = 8'h31; 8'h2f: sbox = 8'h15;
      8'h30: sbox = 8'h04; 8'h31: sbox = 8'hc7; 8'h32: sbox = 8'h23; 8'h33: sbox = 8'hc3; 8'h34: sbox = 8'h18; 8'h35: sbox = 8'h96; 8'h36: sbox = 8'h05; 8'h37: sbox = 8'h9a;
      8'h38: sbox = 8'h07; 8'h39: sbox = 8'h12; 8'h3a: sbox = 8'h80; 8'h3b: sbox = 8'he2; 8'h3c: sbox = 8'heb; 8'h3d: sbox = 8'h27; 8'h3e: sbox = 8'hb2; 8'h3f: sbox = 8'h75;
      8'h40: sbox = 8'h09; 8'h41: sbox = 8'h83; 8'h42: sbox = 8'h2c; 8'h43: sbox = 8'h1a; 8'h44: sbox = 8'h1b; 8'h45: sbox = 8'h6e; 8'h46: sbox = 8'h5a; 8'h47: sbox = 8'ha0;
      8'h48: sbox = 8'h52; 8'h49: sbox = 8'h3b; 8'h4a: sbox = 8'hd6; 8'h4b: sbox = 8'hb3; 8'h4c: sbox = 8'h29; 8'h4d: sbox = 8'he3; 8'h4e: sbox = 8'h2f; 8'h4f: sbox = 8'h84;
      8'h50: sbox = 8'h53; 8'h51: sbox = 8'hd1; 8'h52: sbox = 8'h00; 8'h53: sbox = 8'hed; 8'h54: sbox = 8'h20; 8'h55: sbox = 8'hfc; 8'h56: sbox = 8'hb1; 8'h57: sbox = 8'h5b;
      8'h58: sbox = 8'h6a; 8'h59: sbox = 8'hcb; 8'h5a: sbox = 8'hbe; 8'h5b: sbox = 8'h39; 8'h5c: sbox = 8'h4a; 8'h5d: sbox = 8'h4c; 8'h5e: sbox = 8'h58; 8'h5f: sbox = 8'hcf;
      8'h60: sbox = 8'hd0; 8'h61: sbox = 8'hef; 8'h62: sbox = 8'haa; 8'h63: sbox = 8'hfb; 8'h64: sbox = 8'h43; 8'h65: sbox = 8'h4d; 8'h66: sbox = 8'h33; 8'h67: sbox = 8'h85;
      8'h68: sbox = 8'h45; 8'h69: sbox = 8'hf9; 8'h6a: sbox = 8'h02; 8'h6b: sbox = 8'h7f; 8'h6c: sbox = 8'h50; 8'h6d: sbox = 8'h3c; 8'h6e: sbox = 8'h9f; 8'h6f: sbox = 8'ha8;
      8'h70: sbox = 8'h51; 8'h71: sbox = 8'ha3; 8'h72: sbox = 8'h40; 8'h73: sbox = 8'h8f; 8'h74: sbox = 8'h92; 8'h75: sbox = 8'h9d; 8'h76: sbox = 8'h38; 8'h77: sbox = 8'hf5;
      8'h78: sbox = 8'hbc; 8'h79: sbox = 8'hb6; 8'h7a: sbox = 8'hda; 8'h7b: sbox = 8'h21; 8'h7c: sbox = 8'h10; 8'h7d: sbox = 8'hff; 8'h7e: sbox = 8'hf3; 8'h7f: sbox = 8'hd2;
      8'h80: sbox = 8'hcd; 8'h81: sbox = 8'h0c; 8'h82: sbox = 8'h13; 8'h83: sbox = 8'hec; 8'h84: sbox = 8'h5f; 8'h85: sbox = 8'h97; 8'h86: sbox = 8'h44; 8'h87: sbox = 8'h17;
      8'h88: sbox = 8'hc4; 8'h89: sbox = 8'ha7; 8'h8a: sbox = 8'h7e; 8'h8b: sbox = 8'h3d; 8'h8c: sbox = 8'h64; 8'h8d: sbox = 8'h5d; 8'h8e: sbox = 8'h19; 8'h8f: sbox = 8'h73;
      8'h90: sbox = 8'h60; 8'h91: sbox = 8'h81; 8'h92: sbox = 8'h4f; 8'h93: sbox = 8'hdc; 8'h94: sbox = 8'h22; 8'h95: sbox = 8'h2a; 8'h96: sbox = 8'h90; 8'h97: sbox = 8'h88;
      8'h98: sbox = 8'h46; 8'h99: sbox = 8'hee; 8'h9a: sbox = 8'hb8; 8'h9b: sbox = 8'h14; 8'h9c: sbox = 8'hde; 8'h9d: sbox = 8'h5e; 8'h9e: sbox = 8'h0b; 8'h9f: sbox = 8'hdb;
      8'ha0: sbox = 8'he0; 8'ha1: sbox = 8'h32; 8'ha2: sbox = 8'h3a; 8'ha3: sbox = 8'h0a; 8'ha4: sbox = 8'h49; 8'ha5: sbox = 8'h06; 8'ha6: sbox = 8'h24; 8'ha7: sbox = 8'h5c;
      8'ha8: sbox = 8'hc2; 8'ha9: sbox = 8'hd3; 8'haa: sbox = 8'hac; 8'hab: sbox = 8'h62; 8'hac: sbox = 8'h91; 8'had: sbox = 8'h95; 8'hae: sbox = 8'he4; 8'haf: sbox = 8'h79;
      8'hb0: sbox = 8'he7; 8'hb1: sbox = 8'hc8; 8'hb2: sbox = 8'h37; 8'hb3: sbox = 8'h6d; 8'hb4: sbox = 8'h8d; 8'hb5: sbox = 8'hd5; 8'hb6: sbox = 8'h4e; 8'hb7: sbox = 8'ha9;
      8'hb8: sbox = 8'h6c; 8'hb9: sbox = 8'h56; 8'hba: sbox = 8'hf4; 8'hbb: sbox = 8'hea; 8'hbc: sbox = 8'h65; 8'hbd: sbox = 8'h7a; 8'hbe: sbox = 8'hae; 8'hbf: sbox = 8'h08;
      8'hc0: sbox = 8'hba; 8'hc1: sbox = 8'h78; 8'hc2: sbox = 8'h25; 8'hc3: sbox = 8'h2e; 8'hc4: sbox = 8'h1c; 8'hc5: sbox = 8'ha6; 8'hc6: sbox = 8'hb4; 8'hc7: sbox = 8'hc6;
      8'hc8: sbox = 8'he8; 8'hc9: sbox = 8'hdd; 8'hca: sbox = 8'h74; 8'hcb: sbox = 8'h1f; 8'hcc: sbox = 8'h4b; 8'hcd: sbox = 8'hbd; 8'hce: sbox = 8'h8b; 8'hcf: sbox = 8'h8a;
      8'hd0: sbox = 8'h70; 8'hd1: sbox = 8'h3e; 8'hd2: sbox = 8'hb5; 8'hd3: sbox = 8'h66; 8'hd4: sbox = 8'h48; 8'hd5: sbox = 8'h03; 8'hd6: sbox = 8'hf6; 8'hd7: sbox = 8'h0e;
      8'hd8: sbox = 8'h61; 8'hd9: sbox = 8'h35; 8'hda: sbox = 8'h57; 8'hdb: sbox = 8'hb9; 8'hdc: sbox = 8'h86; 8'hdd: sbox = 8'hc1; 8'hde: sbox = 8'h1d; 8'hdf: sbox = 8'h9e;
      8'he0: sbox = 8'he1; 8'he1: sbox = 8'hf8; 8'he2: sbox = 8'h98; 8'he3: sbox = 8'h11; 8'he4: sbox = 8'h69; 8'he5: sbox = 8'hd9; 8'he6: sbox = 8'h8e; 8'he7: sbox = 8'h94;
      8'he8: sbox = 8'h9b; 8'he9: sbox = 8'h1e; 8'hea: sbox = 8'h87; 8'heb: sbox = 8'he9; 8'hec: sbox = 8'hce; 8'hed: sbox = 8'h55; 8'hee: sbox = 8'h28; 8'hef: sbox = 8'hdf;
      8'hf0: sbox = 8'h8c; 8'hf1: sbox = 8'ha1; 8'hf2: sbox = 8'h89; 8'hf3: sbox = 8'h0d; 8'hf4: sbox = 8'hbf; 8'hf5: sbox = 8'he6; 8'hf6: sbox = 8'h42; 8'hf7: sbox = 8'h68;
      8'hf8: sbox = 8'h41; 8'hf9: sbox = 8'h99; 8'hfa: sbox = 8'h2d; 8'hfb: sbox = 8'h0f; 8'hfc: sbox = 8'hb0; 8'hfd: sbox = 8'h54; 8'hfe: sbox = 8'hbb; 8'hff: sbox = 8'h16;
      default: sbox = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [2:0] r);
    rcon = 8'h00;
    case (r)
      3'd1: rcon = 8'h01; 3'd2: rcon = 8'h02; 3'd3: rcon = 8'h04; 3'd4: rcon = 8'h08;
      3'd5: rcon = 8'h10; 3'd6: rcon = 8'h20; 3'd7: rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Indices are clamped so reads stay inside storage while i is below 8 (idle/reset).
  always_comb begin
    idx_prev = (i >= 6'd8) ? i - 6'd1 : 6'd0;
    idx_back = (i >= 6'd8) ? i - 6'd8 : 6'd0;
    w_prev   = w[idx_prev];
    case (i[2:0])
      3'd0:    temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon(i[5:3]), 24'h0};
      3'd4:    temp = sub_word(w_prev);
      default: temp = w_prev;
    endcase
    w_new = w[idx_back] ^ temp;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (En) state_nx = EXPAND;
      EXPAND:  if (i == 6'd59) state_nx = DONE;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      i     <= 6'd0;
      ready <= 1'b0;
      for (int k = 0; k < 60; k++) w[k] <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == IDLE && En) begin
        for (int k = 0; k < 8; k++) w[k] <= data_in[255-32*k -: 32];
        i <= 6'd8;
      end else if (state == EXPAND) begin
        w[i] <= w_new;
        i    <= i + 6'd1;
        if (i == 6'd59) ready <= 1'b1;
      end
    end
  end

  always_comb begin
    base    = {Addr_Key, 2'b00};
    Out_Key = 128'h0;
    if (Addr_Key != 4'd15)
      Out_Key = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
  end

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: reference schedule built from GF(2^8) arithmetic
// (S-box derived from inversion plus affine map), random and FIPS-197 keys.
module tb_key_expansion;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         En;
  logic [255:0] data_in;
  logic [3:0]   Addr_Key;
  logic         ready;
  logic [127:0] Out_Key;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  sbox_t [256];
  logic [31:0] ref_w  [60];

  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  key_expansion dut (
    .Clk(Clk), .Rst(Rst), .En(En), .data_in(data_in),
    .Addr_Key(Addr_Key), .ready(ready), .Out_Key(Out_Key)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    d = d << n;
    return d[15:8];
  endfunction

  task automatic build_sbox;
    logic [7:0] inv, xb, yb;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = y[7:0];
        if (gmul(xb, yb) == 8'h01) inv = yb;
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_ref(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  task automatic model(input logic [255:0] key);
    logic [7:0]  rc;
    logic [31:0] t;
    for (int k = 0; k < 8; k++) ref_w[k] = key[255-32*k -: 32];
    rc = 8'h01;
    for (int n = 8; n < 60; n++) begin
      t = ref_w[n-1];
      if (n % 8 == 0) begin
        t  = sub_word_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (n % 8 == 4) begin
        t = sub_word_ref(t);
      end
      ref_w[n] = ref_w[n-8] ^ t;
    end
  endtask

  function automatic logic [127:0] ref_key(input int a);
    if (a == 15) return 128'h0;
    return {ref_w[4*a], ref_w[4*a+1], ref_w[4*a+2], ref_w[4*a+3]};
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) begin
      @(negedge Clk);
      Addr_Key = a[3:0];
      #1;
      check($sformatf("%s[%0d]", tag, a), Out_Key, ref_key(a));
    end
  endtask

  task automatic sweep_zero(input string tag, input bit stir);
    for (int a = 0; a < 16; a++) begin
      @(negedge Clk);
      Addr_Key = a[3:0];
      if (stir) begin
        En      = 1'($urandom_range(0, 1));
        data_in = rand_key();
      end
      #1;
      check($sformatf("%s[%0d]", tag, a), Out_Key, 128'h0);
    end
  endtask

  task automatic check_addr(input string tag, input int a, input logic [127:0] exp);
    @(negedge Clk);
    Addr_Key = a[3:0];
    #1;
    check(tag, Out_Key, exp);
  endtask

  task automatic do_reset;
    @(negedge Clk);
    Rst = 1'b0;
    En  = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  // Drives En for one edge, scrambles data_in afterwards, counts edges to ready.
  task automatic run_key(input string tag, input logic [255:0] key);
    int edges;
    model(key);
    edges = 0;
    @(negedge Clk);
    data_in = key;
    En      = 1'b1;
    while (edges < 200) begin
      @(posedge Clk);
      edges++;
      #1;
      if (edges == 1) begin
        En      = 1'b0;
        data_in = rand_key();
      end
      if (ready) break;
    end
    check({tag, "_latency"}, 128'(edges), 128'd53);
    check({tag, "_ready"}, 128'(ready), 128'd1);
    sweep(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst      = 1'b0;
    En       = 1'($urandom_range(0, 1));
    data_in  = rand_key();
    Addr_Key = 4'd0;
    build_sbox();

    repeat (3) begin
      @(negedge Clk);
      En      = 1'($urandom_range(0, 1));
      data_in = rand_key();
    end
    check("reset_ready", 128'(ready), 128'd0);
    sweep_zero("reset_zero", 1'b1);

    @(negedge Clk);
    En  = 1'b0;
    Rst = 1'b1;
    repeat (5) @(negedge Clk);
    check("idle_no_start", 128'(ready), 128'd0);

    run_key("c3", KEY_C3);
    check_addr("c3_addr0",  0,  128'h000102030405060708090a0b0c0d0e0f);
    check_addr("c3_addr1",  1,  128'h101112131415161718191a1b1c1d1e1f);
    check_addr("c3_addr2",  2,  128'ha573c29fa176c498a97fce93a572c09c);
    check_addr("c3_addr14", 14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    check_addr("c3_addr15", 15, 128'h0);

    repeat (8) begin
      @(negedge Clk);
      En      = ~En;
      data_in = rand_key();
    end
    En = 1'b1;
    repeat (3) @(negedge Clk);
    check("done_ready_held", 128'(ready), 128'd1);
    sweep("done_stable");
    En = 1'b0;

    do_reset();
    run_key("a3", KEY_A3);
    check_addr("a3_addr2",  2,  128'h9ba354118e6925afa51a8b5f2067fcde);
    check_addr("a3_addr14", 14, 128'hfe4890d1e6188d0b046df344706c631e);

    do_reset();
    @(negedge Clk);
    data_in = rand_key();
    En      = 1'b1;
    @(negedge Clk);
    En = 1'b0;
    repeat (19) @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("midreset_ready", 128'(ready), 128'd0);
    sweep_zero("midreset_zero", 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    run_key("a3_rerun", KEY_A3);
    check_addr("a3_rerun_addr2",  2,  128'h9ba354118e6925afa51a8b5f2067fcde);
    check_addr("a3_rerun_addr14", 14, 128'hfe4890d1e6188d0b046df344706c631e);

    for (int t = 0; t < 4; t++) begin
      do_reset();
      run_key($sformatf("rand%0d", t), rand_key());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_expansion.md
# key_expansion

AES-256 key schedule engine. Accepts a 256-bit cipher key, iteratively expands it into the 60 schedule words (15 round keys of 128 bits) defined by FIPS-197, and stores them internally. After completion, the AES round datapath reads any round key combinationally by index.

## Interface
Parameters: none; the block is fixed to AES-256.

- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `En`  in  1  start request, sampled on the rising edge while idle.
- `data_in`  in  256  cipher key; `[255:224]` = w0 … `[31:0]` = w7.
- `Addr_Key`  in  4  round-key index, 0..14.
- `ready`  out  1  registered; high once all 60 words are valid.
- `Out_Key`  out  128  round key `Addr_Key` = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in `[127:96]`.

## Operation
- Storage: 60 × 32-bit word registers, plus a 6-bit word counter `i` and a state register.
- States:
  - IDLE: waits for a start request.
  - EXPAND: generates one word per clock.
  - DONE: holds the schedule.
- IDLE → EXPAND: on a rising edge with `En`=1.
  - w0..w7 are loaded from `data_in`.
  - `i` is set to 8.
- EXPAND: each edge computes w[i] = w[i-8] ^ temp and increments `i`. `temp` depends on `i mod 8`:
  - `i mod 8` = 0: SubWord(RotWord(w[i-1])) ^ {Rcon[i/8], 24'h0}.
  - `i mod 8` = 4: SubWord(w[i-1]).
  - otherwise: w[i-1].
- Rcon[1..7] = 01, 02, 04, 08, 10, 20, 40 (hex).
- RotWord: {b1, b2, b3, b0}. SubWord: the AES S-box applied to each byte.
  - One word per cycle, so four S-box lookups per cycle.
  - The S-box is a combinational 256-entry case function inside the block.
- EXPAND → DONE: on the edge that writes w59 (`i`=59). `ready` goes high on that same edge.
- DONE persists until reset.
  - `En` is ignored in DONE, whether held high or toggled.
  - Re-keying requires asserting `Rst`.
- `data_in` is sampled only on the load edge. Later changes have no effect.
- `Out_Key` is purely combinational from `Addr_Key` and the word storage.
  - `Addr_Key` = 15 drives all-zero.
  - Before `ready`, `Out_Key` shows the current (possibly partial or zero) storage contents. It is not guaranteed meaningful.

## Timing
- Reset (`Rst`=0, any time, including mid-expansion):
  - all words = 0, `i` = 0, state = IDLE, `ready` = 0.
  - Consequently `Out_Key` = 0 for every address.
- Reset release: the block sits in IDLE until it samples `En`=1.
- Latency:
  - load on edge k;
  - words w8..w59 on edges k+1..k+52;
  - `ready` = 1 after edge k+52, i.e. 53 rising edges after the first `En`=1 sample.
- Address read: zero-cycle latency. `Out_Key` is valid in the same cycle `Addr_Key` changes, once `ready`=1.
- `ready` is monotonic between resets.

## Test plan
- **Reset values:** hold `Rst`=0 with random `data_in` and `En` → `ready`=0 and `Out_Key`=0 for all 16 `Addr_Key` values.
- **FIPS-197 C.3 key:** key = 000102…1e1f, `En`=1, wait for `ready`, then sweep `Addr_Key` 0..15 →
  - addr 0 = 000102030405060708090a0b0c0d0e0f
  - addr 1 = 101112131415161718191a1b1c1d1e1f
  - addr 2 = a573c29fa176c498a97fce93a572c09c
  - addr 14 = 24fc79ccbf0979e9371ac23c6d68de36
  - addr 15 = 0
- **FIPS-197 A.3 key:** key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 →
  - addr 2 = 9ba354118e6925afa51a8b5f2067fcde
  - addr 14 = fe4890d1e6188d0b046df344706c631e
- **Latency:** count edges from the first `En`=1 sample to `ready` rising → exactly 53. Changing `data_in` after the load edge does not alter the results.
- **Reset mid-expansion:** pulse `Rst` low 20 cycles after start → `ready`=0 and all keys 0. Then re-run with the A.3 key → same A.3 results, no residue.
- **DONE stability:** after `ready`, toggle `En` and change `data_in` → `ready` stays 1 and all 15 round keys remain unchanged.
